run_ctrl: RTL and testbench
===========================

Name: run_ctrl

Overview:
Board-level run controller for the pipelined MIPS CPU. It synchronizes and debounces the run/reset/speed switches and a single-step button, and sequences CPU execution. Execution is driven by a one-cycle clock-enable pulse (cpu_en) at a selectable rate, so no derived or gated clocks are used. It sits between the board switch inputs and the CPU core's enable/reset inputs, and it also reports run status and the executed-cycle count to the display logic.

Parameters:
DIV_BASE, 100_000_000, tick period in clk cycles at speed 0 (1 Hz at 100 MHz)
DEB_CYCLES, 1_000_000, consecutive stable samples required to accept a new debounced level
CNT_W, 32, width of cycle_cnt

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
sw_go  in  1  raw switch; 1 = run, 0 = pause
sw_rst  in  1  raw switch; 1 = hold CPU in reset
sw_speed  in  1  raw switch; each debounced rising edge advances the speed
btn_step  in  1  raw button; each debounced rising edge advances the CPU one cycle while paused
cpu_en  out  1  one-cycle CPU clock-enable pulse
cpu_rst  out  1  CPU reset, active-high
speed_sel  out  2  current speed index
running  out  1  1 while in RUN state
cycle_cnt  out  CNT_W  number of cpu_en pulses issued since the last HOLD

Behaviour:
- Reset values: state=HOLD, cpu_rst=1, cpu_en=0, speed_sel=0, running=0, cycle_cnt=0. All debounced levels=0, tick counter=0.
- Input conditioning:
  - Every raw input passes through a 2-FF synchronizer, then a debouncer.
  - The debounced level changes only after DEB_CYCLES consecutive synchronized samples differ from the current level; any mismatch-then-match restarts the count.
  - Rising-edge detect runs on the debounced sw_speed and btn_step. Total input-to-debounced latency is 2 + DEB_CYCLES clk cycles.
- Speed:
  - speed_sel increments on each sw_speed debounced rise and wraps 3->0.
  - Tick period P = DIV_BASE >> {0,1,2,4}[speed_sel], giving rates 1x, 2x, 4x, 16x.
  - P is clamped to a minimum of 1.
- Tick counter:
  - Counts 0..P-1 and asserts tick for the cycle in which it equals P-1, then wraps to 0.
  - It clears to 0 on a speed change and whenever the state is not RUN, so the first tick after entering RUN occurs P cycles later.
- FSM states HOLD, PAUSE, RUN, STEP:
  - HOLD: cpu_rst=1, cycle_cnt cleared. Goes to PAUSE when debounced sw_rst=0.
  - PAUSE: goes to HOLD if sw_rst=1; else to RUN if go=1; else to STEP on a btn_step rise.
  - RUN: cpu_en=tick, running=1. Goes to HOLD if sw_rst=1, else to PAUSE if go=0.
  - STEP: cpu_en=1 for exactly one cycle, then PAUSE; sw_rst=1 goes to HOLD instead.
- Priority: rst > sw_rst > go > step. A step edge arriving while in RUN or HOLD is discarded, not queued.
- Output timing: cpu_en and cpu_rst are registered outputs of the FSM. cpu_en is never asserted while cpu_rst=1.
- cycle_cnt increments by 1 on every cpu_en pulse and wraps at 2^CNT_W.
- rst mid-RUN: outputs return to their reset values on the next clk edge; speed_sel also returns to 0.

Optional Feature:
Macro RUN_CTRL_BREAK_EN.
- Enabled: adds input ports pc[31:0], brk_addr[31:0], brk_valid. In RUN, if brk_valid=1 and pc==brk_addr in the cycle after a cpu_en pulse, the FSM goes to PAUSE and sets sticky output brk_hit=1. RUN is re-entered only after go is seen 0 then 1. brk_hit clears on leaving PAUSE or on HOLD; its reset value is 0.
- Disabled: these ports do not exist and behaviour is exactly as above.

Decomposition:
- Package run_ctrl_pkg holds:
  - the state enum (HOLD, PAUSE, RUN, STEP);
  - the shift table {0,1,2,4};
  - localparam SPEED_W=2.
- One sub-module, sw_debounce (2-FF synchronizer + DEB_CYCLES counter + rise output), instantiated 4 times.

Test Plan:
All scenarios use DIV_BASE=16, DEB_CYCLES=4.
1. Reset release with sw_rst=0 and go=0: cpu_rst=1 during reset and falls once the FSM reaches PAUSE (within 2 cycles after rst deasserts); cpu_en stays 0 for 100 cycles and cycle_cnt stays 0.
2. go=1 held for 200 cycles: running=1 once go is debounced, then cpu_en pulses every 16 cycles, each exactly 1 cycle wide; cycle_cnt is 11 or 12 at the end.
3. Four sw_speed pulses, each held 10 cycles, with go=1: speed_sel steps 1,2,3,0 and the cpu_en spacing measures 8, 4, 1, 16.
4. go=0 with three btn_step presses: exactly 3 cpu_en pulses and cycle_cnt=3. A 2-cycle glitch on btn_step produces no pulse.
5. sw_rst=1 during RUN: cpu_rst=1 and cpu_en=0 from the next cycle, cycle_cnt=0. After sw_rst drops, the FSM is in PAUSE if go=0, or returns to RUN if go=1.
6. RUN_CTRL_BREAK_EN with brk_addr=0x40, pc stepping by 4 per cpu_en: the FSM stops in PAUSE with brk_hit=1. cpu_en stays 0 until go is toggled 0->1.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// run_ctrl_pkg
//   Shared types and constants for the run controller: the FSM state
//   encoding, the speed index width and the per-speed shift table that
//   turns the base divider into the tick period.
// -----------------------------------------------------------------------------
package run_ctrl_pkg;

    localparam int SPEED_W = 2;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_PAUSE = 2'd1,
        ST_RUN   = 2'd2,
        ST_STEP  = 2'd3
    } state_e;

    // Right-shift applied to the base divider for each speed index:
    // rates of 1x, 2x, 4x and 16x.
    localparam logic [2:0] SPEED_SHIFT [4] = '{3'd0, 3'd1, 3'd2, 3'd4};

    // Tick period in clk cycles for a given speed. A small base divider can
    // shift down to zero; a period of one (tick every cycle) is the floor.
    function automatic logic [31:0] tick_period(input logic [31:0]        base,
                                                input logic [SPEED_W-1:0] speed);
        logic [31:0] p;
        p = base >> SPEED_SHIFT[speed];
        return (p == 32'd0) ? 32'd1 : p;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
//   Conditions one raw board input: 2-FF synchronizer followed by a
//   stability counter. The debounced level flips only after DEB_CYCLES
//   consecutive synchronized samples disagree with it; any sample that
//   agrees restarts the count. Input-to-level latency is 2 + DEB_CYCLES.
//
// Ports
//   clk      in   system clock
//   rst      in   synchronous, active-high reset (level and counter to 0)
//   din_i    in   raw asynchronous input
//   level_o  out  debounced level
//   rise_o   out  one-cycle pulse in the first cycle level_o reads 1
// -----------------------------------------------------------------------------
module sw_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic din_i,
    output logic level_o,
    output logic rise_o
);

    localparam int              CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every variable written here gets a default before any branch,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                // Level only moves toward the sample, so this is 0->1.
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its source, making the synchronizer
    // chain two real stages regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/run_ctrl.sv
// -----------------------------------------------------------------------------
// run_ctrl
//   Board-level run controller for the pipelined CPU. Debounces the
//   run/reset/speed switches and the single-step button and sequences CPU
//   execution through a one-cycle clock-enable pulse (no derived clocks).
//
//   States: HOLD (CPU held in reset), PAUSE, RUN (cpu_en on each tick),
//   STEP (exactly one cpu_en). Priority: rst > sw_rst > go > step.
//
// Parameters
//   DIV_BASE    tick period in clk cycles at speed 0
//   DEB_CYCLES  stable samples needed to accept a new debounced level
//   CNT_W       width of cycle_cnt
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   sw_go      in   raw switch, 1 = run, 0 = pause
//   sw_rst     in   raw switch, 1 = hold CPU in reset
//   sw_speed   in   raw switch, each debounced rise advances speed_sel
//   btn_step   in   raw button, each debounced rise steps one cycle in PAUSE
//   cpu_en     out  registered one-cycle CPU clock enable
//   cpu_rst    out  registered CPU reset, active-high
//   speed_sel  out  current speed index (period DIV_BASE >> {0,1,2,4})
//   running    out  1 while in RUN
//   cycle_cnt  out  cpu_en pulses since the last HOLD, wraps at 2^CNT_W
//
// Optional feature, macro RUN_CTRL_BREAK_EN
//   Adds pc, brk_addr, brk_valid inputs and sticky brk_hit output. In RUN,
//   a pc match in the cycle after a cpu_en pulse drops to PAUSE; RUN is
//   re-entered only after go is seen 0 then 1.
// -----------------------------------------------------------------------------
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int DIV_BASE   = 100_000_000,
    parameter int DEB_CYCLES = 1_000_000,
    parameter int CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sw_go,
    input  logic               sw_rst,
    input  logic               sw_speed,
    input  logic               btn_step,
`ifdef RUN_CTRL_BREAK_EN
    input  logic [31:0]        pc,
    input  logic [31:0]        brk_addr,
    input  logic               brk_valid,
    output logic               brk_hit,
`endif
    output logic               cpu_en,
    output logic               cpu_rst,
    output logic [SPEED_W-1:0] speed_sel,
    output logic               running,
    output logic [CNT_W-1:0]   cycle_cnt
);

    localparam logic [31:0] DIV_BASE_W = 32'(DIV_BASE);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic go_lvl, hold_lvl, speed_rise, step_rise;
    logic go_rise_unused, hold_rise_unused, speed_lvl_unused, step_lvl_unused;

    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_go (
        .clk     (clk),
        .rst     (rst),
        .din_i   (sw_go),
        .level_o (go_lvl),
        .rise_o  (go_rise_unused)
    );

    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_rst (
        .clk     (clk),
        .rst     (rst),
        .din_i   (sw_rst),
        .level_o (hold_lvl),
        .rise_o  (hold_rise_unused)
    );

    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_speed (
        .clk     (clk),
        .rst     (rst),
        .din_i   (sw_speed),
        .level_o (speed_lvl_unused),
        .rise_o  (speed_rise)
    );

    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
        .clk     (clk),
        .rst     (rst),
        .din_i   (btn_step),
        .level_o (step_lvl_unused),
        .rise_o  (step_rise)
    );

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_e             state_q, state_d;
    logic               cpu_en_q, cpu_en_d;
    logic               cpu_rst_q, cpu_rst_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [31:0]        tick_cnt_q, tick_cnt_d;
    logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;

    logic [31:0]        period;
    logic               tick;
    logic               go_ok;

    assign period = tick_period(DIV_BASE_W, speed_q);
    assign tick   = (tick_cnt_q == (period - 32'd1));

`ifdef RUN_CTRL_BREAK_EN
    logic brk_hit_q, brk_hit_d;
    logic brk_armed_q, brk_armed_d;
    logic en_dly_q;
    logic brk_match;

    // The CPU advances pc on the cpu_en edge, so the new pc is compared
    // in the cycle after the pulse.
    assign brk_match = en_dly_q && brk_valid && (pc == brk_addr);
    // After a breakpoint, go must be seen low before RUN is allowed again.
    assign go_ok     = go_lvl && (!brk_hit_q || brk_armed_q);
`else
    assign go_ok     = go_lvl;
`endif

    // ------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
`ifdef RUN_CTRL_BREAK_EN
        brk_hit_d   = brk_hit_q;
        brk_armed_d = brk_armed_q;
`endif
        case (state_q)
            ST_HOLD: begin
                if (!hold_lvl) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (hold_lvl)       state_d = ST_HOLD;
                else if (go_ok)     state_d = ST_RUN;
                else if (step_rise) state_d = ST_STEP;
            end
            ST_RUN: begin
                if (hold_lvl) begin
                    state_d = ST_HOLD;
`ifdef RUN_CTRL_BREAK_EN
                end else if (brk_match) begin
                    state_d   = ST_PAUSE;
                    brk_hit_d = 1'b1;
`endif
                end else if (!go_lvl) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_STEP: begin
                state_d = hold_lvl ? ST_HOLD : ST_PAUSE;
            end
            default: state_d = ST_HOLD;
        endcase

`ifdef RUN_CTRL_BREAK_EN
        if (state_q == ST_PAUSE && brk_hit_q && !go_lvl) brk_armed_d = 1'b1;
        if (state_d == ST_HOLD || (state_q == ST_PAUSE && state_d != ST_PAUSE)) begin
            brk_hit_d   = 1'b0;
            brk_armed_d = 1'b0;
        end
`endif

        // Outputs are decoded from the next state so they are registered
        // alongside it; cpu_en can only be set outside HOLD, which keeps it
        // mutually exclusive with cpu_rst.
        cpu_rst_d = (state_d == ST_HOLD);
        cpu_en_d  = (state_d == ST_STEP) ||
                    (state_q == ST_RUN && state_d == ST_RUN && tick);

        speed_d = speed_q + SPEED_W'(speed_rise);

        // Counter restarts on a speed change and outside RUN so the first
        // tick after entering RUN comes a full period later.
        if (state_q != ST_RUN || speed_rise || tick) tick_cnt_d = 32'd0;
        else                                         tick_cnt_d = tick_cnt_q + 32'd1;

        if (state_d == ST_HOLD) cycle_cnt_d = '0;
        else                    cycle_cnt_d = cycle_cnt_q + CNT_W'(cpu_en_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_HOLD;
            cpu_en_q    <= 1'b0;
            cpu_rst_q   <= 1'b1;
            speed_q     <= '0;
            tick_cnt_q  <= 32'd0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cpu_en_q    <= cpu_en_d;
            cpu_rst_q   <= cpu_rst_d;
            speed_q     <= speed_d;
            tick_cnt_q  <= tick_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

`ifdef RUN_CTRL_BREAK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            brk_hit_q   <= 1'b0;
            brk_armed_q <= 1'b0;
            en_dly_q    <= 1'b0;
        end else begin
            brk_hit_q   <= brk_hit_d;
            brk_armed_q <= brk_armed_d;
            en_dly_q    <= cpu_en_q;
        end
    end

    assign brk_hit = brk_hit_q;
`endif

    assign cpu_en    = cpu_en_q;
    assign cpu_rst   = cpu_rst_q;
    assign speed_sel = speed_q;
    assign running   = (state_q == ST_RUN);
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_run_ctrl
//   Directed sequence with randomized durations and press counts for
//   run_ctrl (DIV_BASE=16, DEB_CYCLES=4). Expected values come from the
//   controller's rules expressed as latencies and periods: a raw switch
//   reaches the FSM 2 + DEB_CYCLES + 1 edges later, and in RUN a pulse
//   appears every P = DIV_BASE / rate cycles.
//   Define RUN_CTRL_BREAK_EN to also exercise the breakpoint feature.
// -----------------------------------------------------------------------------
module tb_run_ctrl;

    localparam int DIV_BASE   = 16;
    localparam int DEB_CYCLES = 4;
    localparam int CNT_W      = 32;
    localparam int FSM_LAT    = 2 + DEB_CYCLES + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             sw_go, sw_rst, sw_speed, btn_step;
    logic             cpu_en, cpu_rst, running;
    logic [1:0]       speed_sel;
    logic [CNT_W-1:0] cycle_cnt;
`ifdef RUN_CTRL_BREAK_EN
    logic [31:0]      pc;
    logic [31:0]      brk_addr;
    logic             brk_valid;
    logic             brk_hit;
`endif

    always #5 clk = ~clk;

    run_ctrl #(
        .DIV_BASE   (DIV_BASE),
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_go     (sw_go),
        .sw_rst    (sw_rst),
        .sw_speed  (sw_speed),
        .btn_step  (btn_step),
`ifdef RUN_CTRL_BREAK_EN
        .pc        (pc),
        .brk_addr  (brk_addr),
        .brk_valid (brk_valid),
        .brk_hit   (brk_hit),
`endif
        .cpu_en    (cpu_en),
        .cpu_rst   (cpu_rst),
        .speed_sel (speed_sel),
        .running   (running),
        .cycle_cnt (cycle_cnt)
    );

`ifdef RUN_CTRL_BREAK_EN
    // Minimal CPU: pc advances by 4 on each enabled cycle.
    always @(posedge clk) begin
        if (rst || cpu_rst) pc <= 32'd0;
        else if (cpu_en)    pc <= pc + 32'd4;
    end
`endif

    // Pulse monitor, sampled on the falling edge.
    int   cyc        = 0;
    int   pulses     = 0;
    int   wide       = 0;
    int   overlap    = 0;
    int   last_pulse = 0;
    int   last_gap   = 0;
    logic prev_en    = 1'b0;

    always @(negedge clk) begin
        cyc     <= cyc + 1;
        prev_en <= cpu_en;
        if (cpu_en) begin
            pulses     <= pulses + 1;
            last_gap   <= cyc - last_pulse;
            last_pulse <= cyc;
            if (prev_en) wide    <= wide + 1;
            if (cpu_rst) overlap <= overlap + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_running(input logic want, input int budget, output int n);
        n = 0;
        while (running !== want && n < budget) begin
            step(1);
            n++;
        end
    endtask

    task automatic wait_cpu_rst(input logic want, input int budget, output int n);
        n = 0;
        while (cpu_rst !== want && n < budget) begin
            step(1);
            n++;
        end
    endtask

    int n, dur, p0, c0, w0, presses, per;
    int rate_seq [4];

    initial begin
        rate_seq[0] = 2; rate_seq[1] = 4; rate_seq[2] = 16; rate_seq[3] = 1;
        rst = 1'b1; sw_go = 1'b0; sw_rst = 1'b0; sw_speed = 1'b0; btn_step = 1'b0;
`ifdef RUN_CTRL_BREAK_EN
        brk_addr = 32'h40; brk_valid = 1'b0;
`endif
        // 1. Reset state and release into PAUSE.
        step(5);
        check("reset_cpu_rst", 32'(cpu_rst), 1);
        check("reset_cpu_en", 32'(cpu_en), 0);
        check("reset_speed", 32'(speed_sel), 0);
        check("reset_running", 32'(running), 0);
        check("reset_cycle_cnt", cycle_cnt, 0);
        rst = 1'b0;
        wait_cpu_rst(1'b0, 2, n);
        check("hold_exit_cpu_rst", 32'(cpu_rst), 0);
        p0 = pulses;
        step(100);
        check("idle_pulses", pulses - p0, 0);
        check("idle_cycle_cnt", cycle_cnt, 0);
        check("idle_running", 32'(running), 0);

        // 2. Run at speed 0 for a random duration.
        dur = 150 + int'($urandom_range(0, 100));
        p0 = pulses; w0 = wide;
        sw_go = 1'b1;
        wait_running(1'b1, 20, n);
        check("go_latency", n, FSM_LAT);
        step(dur - n);
        check("run_cycle_cnt", cycle_cnt, (dur - FSM_LAT) / DIV_BASE);
        check("run_pulses", pulses - p0, (dur - FSM_LAT) / DIV_BASE);
        check("run_pulse_width", wide - w0, 0);
        check("run_gap", last_gap, DIV_BASE);

        // 3. Cycle through all four speeds while running.
        for (int i = 0; i < 4; i++) begin
            per = DIV_BASE / rate_seq[i];
            sw_speed = 1'b1;
            step(10);
            sw_speed = 1'b0;
            step(3 * per + 20);
            check("speed_sel", 32'(speed_sel), (i + 1) % 4);
            check("speed_gap", last_gap, per);
        end

        // rst mid-RUN at a non-zero speed.
        sw_speed = 1'b1;
        step(10);
        sw_speed = 1'b0;
        step(20);
        check("speed_before_rst", 32'(speed_sel), 1);
        rst = 1'b1;
        step(1);
        check("midrun_rst_speed", 32'(speed_sel), 0);
        check("midrun_rst_cpu_rst", 32'(cpu_rst), 1);
        check("midrun_rst_running", 32'(running), 0);
        check("midrun_rst_cycle_cnt", cycle_cnt, 0);
        rst = 1'b0;
        wait_running(1'b1, 20, n);
        check("rerun_after_rst", 32'(running), 1);

        // 4. Single steps while paused, plus a short glitch.
        sw_go = 1'b0;
        wait_running(1'b0, 20, n);
        check("pause_latency", n, FSM_LAT);
        step(20);
        p0 = pulses; c0 = cycle_cnt; w0 = wide;
        presses = int'($urandom_range(2, 4));
        for (int i = 0; i < presses; i++) begin
            btn_step = 1'b1;
            step(DEB_CYCLES + int'($urandom_range(1, 6)));
            btn_step = 1'b0;
            step(DEB_CYCLES + int'($urandom_range(4, 8)));
        end
        btn_step = 1'b1;
        step(int'($urandom_range(1, DEB_CYCLES - 1)));
        btn_step = 1'b0;
        step(20);
        check("step_pulses", pulses - p0, presses);
        check("step_cycle_cnt", cycle_cnt - c0, presses);
        check("step_width", wide - w0, 0);
        check("step_running", 32'(running), 0);

        // 5a. sw_rst during RUN, step press in HOLD, release with go=0.
        sw_go = 1'b1;
        wait_running(1'b1, 20, n);
        check("run_before_hold", 32'(running), 1);
        step(40);
        sw_rst = 1'b1;
        wait_cpu_rst(1'b1, 20, n);
        check("hold_latency", n, FSM_LAT);
        check("hold_cpu_en", 32'(cpu_en), 0);
        check("hold_cycle_cnt", cycle_cnt, 0);
        check("hold_running", 32'(running), 0);
        sw_go = 1'b0;
        btn_step = 1'b1;
        step(10);
        btn_step = 1'b0;
        step(10);
        p0 = pulses;
        sw_rst = 1'b0;
        step(30);
        check("unhold_cpu_rst", 32'(cpu_rst), 0);
        check("unhold_running", 32'(running), 0);
        check("hold_step_discarded", pulses - p0, 0);
        check("unhold_cycle_cnt", cycle_cnt, 0);

        // 5b. sw_rst during RUN, release with go=1 returns to RUN.
        sw_go = 1'b1;
        wait_running(1'b1, 20, n);
        sw_rst = 1'b1;
        wait_cpu_rst(1'b1, 20, n);
        check("hold2_latency", n, FSM_LAT);
`ifdef RUN_CTRL_BREAK_EN
        brk_valid = 1'b1;
`endif
        step(10);
        p0 = pulses;
        sw_rst = 1'b0;
        wait_running(1'b1, 20, n);
        check("rerun_latency", n, FSM_LAT + 1);

`ifdef RUN_CTRL_BREAK_EN
        // 6. Breakpoint at pc 0x40: sixteen pulses, then PAUSE.
        n = 0;
        while (brk_hit !== 1'b1 && n < 400) begin
            step(1);
            n++;
        end
        check("brk_hit", 32'(brk_hit), 1);
        check("brk_running", 32'(running), 0);
        check("brk_pulses", pulses - p0, 16);
        check("brk_pc", pc, 32'h40);
        p0 = pulses;
        step(50);
        check("brk_hold_off", pulses - p0, 0);
        check("brk_stays_paused", 32'(running), 0);
        sw_go = 1'b0;
        step(10);
        sw_go = 1'b1;
        wait_running(1'b1, 30, n);
        check("brk_resume", 32'(running), 1);
        check("brk_hit_cleared", 32'(brk_hit), 0);
`endif

        check("en_rst_overlap", overlap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
